// File: rtl/part2.sv
// ============================================================================
// Module      : part2
// Description : Moore FSM flagging four or more consecutive equal samples of w.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module part2 (
    input  logic [1:0] w_and_Reset,
    input  logic       Clock,
    output logic       z,
    output logic [3:0] present_state
);

    // B..E count a run of 0s, F..I count a run of 1s; E and I saturate.
    typedef enum logic [3:0] {
        ST_A = 4'b0000,
        ST_B = 4'b0001,
        ST_C = 4'b0010,
        ST_D = 4'b0011,
        ST_E = 4'b0100,
        ST_F = 4'b0101,
        ST_G = 4'b0110,
        ST_H = 4'b0111,
        ST_I = 4'b1000
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_rst;
    logic   w_w;

    assign w_rst = w_and_Reset[0];
    assign w_w   = w_and_Reset[1];

    always_ff @(posedge Clock) begin
        if (w_rst) begin
            r_state <= ST_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_A;
        case (r_state)
            ST_A:    w_next = w_w ? ST_F : ST_B;
            ST_B:    w_next = w_w ? ST_F : ST_C;
            ST_C:    w_next = w_w ? ST_F : ST_D;
            ST_D:    w_next = w_w ? ST_F : ST_E;
            ST_E:    w_next = w_w ? ST_F : ST_E;
            ST_F:    w_next = w_w ? ST_G : ST_B;
            ST_G:    w_next = w_w ? ST_H : ST_B;
            ST_H:    w_next = w_w ? ST_I : ST_B;
            ST_I:    w_next = w_w ? ST_I : ST_B;
            // Unused codes fall back to idle on the next edge.
            default: w_next = ST_A;
        endcase
    end

    assign z             = (r_state == ST_E) || (r_state == ST_I);
    assign present_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_part2.sv
// ============================================================================
// Module      : tb_part2
// Description : Directed and randomized checks of part2 against a run-length model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_part2;

    logic [1:0] w_and_Reset;
    logic       Clock;
    logic       z;
    logic [3:0] present_state;

    int n_checks;
    int n_fails;

    // Reference: length and value of the current run of equal samples.
    int r_run_len;
    bit r_run_val;
    bit r_prev_w;

    part2 dut (
        .w_and_Reset   (w_and_Reset),
        .Clock         (Clock),
        .z             (z),
        .present_state (present_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [3:0] model_state();
        int n;
        n = (r_run_len > 4) ? 4 : r_run_len;
        if (n == 0) return 4'd0;
        return r_run_val ? 4'(4 + n) : 4'(n);
    endfunction

    task automatic check_outputs(input string tag, input int exp_code);
        logic [3:0] exp_state;
        logic       exp_z;
        exp_state = model_state();
        exp_z     = (r_run_len >= 4);
        n_checks++;
        assert (present_state === exp_state) else begin
            n_fails++;
            $error("FAIL %s state: observed %b expected %b", tag, present_state, exp_state);
        end
        n_checks++;
        assert (z === exp_z) else begin
            n_fails++;
            $error("FAIL %s z: observed %b expected %b", tag, z, exp_z);
        end
        if (exp_code >= 0) begin
            n_checks++;
            assert (present_state === 4'(exp_code)) else begin
                n_fails++;
                $error("FAIL %s code: observed %b expected %b", tag, present_state, 4'(exp_code));
            end
        end
    endtask

    // Apply one sample, clock it in, advance the model, then compare.
    task automatic step(input bit w, input bit rst, input string tag, input int exp_code);
        @(negedge Clock);
        w_and_Reset = {w, rst};
        @(posedge Clock);
        #1;
        if (rst) begin
            r_run_len = 0;
        end else if (r_run_len == 0 || w != r_run_val) begin
            r_run_val = w;
            r_run_len = 1;
        end else if (r_run_len < 100) begin
            r_run_len++;
        end
        check_outputs(tag, exp_code);
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        r_run_len   = 0;
        r_run_val   = 1'b0;
        w_and_Reset = 2'b01;

        // Reset holds A regardless of w.
        step(1'b1, 1'b1, "rst0", 0);
        step(1'b0, 1'b1, "rst1", 0);
        step(1'b1, 1'b1, "rst2", 0);

        // Run of ones saturates in I.
        step(1'b1, 1'b0, "ones1", 4'b0101);
        step(1'b1, 1'b0, "ones2", 4'b0110);
        step(1'b1, 1'b0, "ones3", 4'b0111);
        step(1'b1, 1'b0, "ones4", 4'b1000);
        step(1'b1, 1'b0, "ones5", 4'b1000);

        // z must not react to w between edges.
        @(negedge Clock);
        w_and_Reset = 2'b10;
        #1;
        w_and_Reset = 2'b00;
        #2;
        n_checks++;
        assert (z === 1'b1) else begin
            n_fails++;
            $error("FAIL z_moore: observed %b expected %b", z, 1'b1);
        end

        // Reset from I, then restart.
        step(1'b1, 1'b1, "rst_from_i", 0);
        step(1'b1, 1'b0, "after_rst", 4'b0101);
        step(1'b0, 1'b1, "rst3", 0);

        // Run of zeros, then one opposite sample.
        step(1'b0, 1'b0, "zeros1", 4'b0001);
        step(1'b0, 1'b0, "zeros2", 4'b0010);
        step(1'b0, 1'b0, "zeros3", 4'b0011);
        step(1'b0, 1'b0, "zeros4", 4'b0100);
        step(1'b1, 1'b0, "break0", 4'b0101);
        step(1'b0, 1'b1, "rst4", 0);

        // Alternating samples never raise z.
        step(1'b1, 1'b0, "alt1", 4'b0101);
        step(1'b0, 1'b0, "alt2", 4'b0001);
        step(1'b1, 1'b0, "alt3", 4'b0101);
        step(1'b0, 1'b0, "alt4", 4'b0001);
        step(1'b0, 1'b1, "rst5", 0);

        // Three ones, a zero, then the one-count restarts.
        step(1'b1, 1'b0, "r1a", 4'b0101);
        step(1'b1, 1'b0, "r1b", 4'b0110);
        step(1'b1, 1'b0, "r1c", 4'b0111);
        step(1'b0, 1'b0, "r0", 4'b0001);
        step(1'b1, 1'b0, "r2a", 4'b0101);
        step(1'b1, 1'b0, "r2b", 4'b0110);
        step(1'b1, 1'b0, "r2c", 4'b0111);

        // Randomized runs with occasional resets.
        r_prev_w = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bit w;
            bit rst;
            w        = ($urandom_range(0, 3) == 0) ? ~r_prev_w : r_prev_w;
            rst      = ($urandom_range(0, 24) == 0);
            r_prev_w = w;
            step(w, rst, "rand", -1);
        end

        $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
